// File: rtl/ddp_assemble.sv
// ddp_assemble: transmit-side DDP packet builder. Packs request header fields into the SOP link word
// and realigns payload through an 11-byte residue. Optional DDP_ASSEMBLE_ZEROPAD_EN zeroes unused last-word bytes.
module ddp_assemble #(
    parameter int LEN_W   = 13,
    parameter int MAX_LEN = 4096
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sendReq,
    output logic             sendAck,
    input  logic [3:0]       sendQN,
    input  logic [LEN_W-1:0] sendLen,
    input  logic [7:0]       sendTID,
    input  logic [7:0]       sendDdpCtrl,
    input  logic [7:0]       sendRdmapCtrl,
    input  logic [55:0]      sendRdmapHdr,
    input  logic [255:0]     sendBufData,
    input  logic             sendBufEmpty,
    output logic             sendBufPop,
    output logic [266:0]     ddpPktDataIn,
    output logic             ddpPktPush,
    input  logic             ddpPktFull,
    output logic [7:0]       sendDoneCtrl,
    output logic [7:0]       sendDoneTID,
    output logic             sendDoneValid
);
    localparam int PC_W = LEN_W - 5;

    typedef enum logic [1:0] {IDLE, SOP, BODY, DONE} state_t;

    typedef struct packed {
        logic [3:0]  qn;
        logic [7:0]  tid;
        logic [7:0]  ddp_ctrl;
        logic [7:0]  rdmap_ctrl;
        logic [55:0] rdmap_hdr;
        logic [8:0]  out_words;
        logic [5:0]  last_be;
    } req_t;

    state_t          state_q, state_d;
    req_t            req_q, req_d;
    logic [8:0]      words_left_q, words_left_d;
    logic [PC_W-1:0] pops_left_q, pops_left_d;
    logic [87:0]     residue_q, residue_d;

    logic [LEN_W-1:0] clamp_len;
    logic [8:0]       new_out_words;
    logic [PC_W-1:0]  new_buf_words;
    logic [5:0]       new_last_be;

    always_comb begin
        clamp_len     = (sendLen > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : sendLen;
        new_out_words = (clamp_len <= LEN_W'(21)) ? 9'd1
                      : 9'd1 + 9'((clamp_len + LEN_W'(10)) >> 5);
        new_buf_words = PC_W'(({1'b0, clamp_len} + (LEN_W+1)'(31)) >> 5);
        // Last-word byte count: whole payload in a single word, else the tail after 21 + 32*k bytes.
        new_last_be   = (new_out_words == 9'd1) ? 6'(clamp_len)
                      : 6'(5'(clamp_len - LEN_W'(22))) + 6'd1;
    end

    logic         last;
    logic [5:0]   be;
    logic [255:0] pkt_data;
    logic         need_pop;

    // NOTE: every signal this block drives gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        words_left_d  = words_left_q;
        pops_left_d   = pops_left_q;
        residue_d     = residue_q;
        sendAck       = 1'b0;
        sendBufPop    = 1'b0;
        ddpPktPush    = 1'b0;
        sendDoneValid = 1'b0;
        last          = 1'b0;
        be            = 6'd0;
        pkt_data      = '0;
        need_pop      = (pops_left_q != '0);

        unique case (state_q)
            IDLE: begin
                if (sendReq) begin
                    sendAck          = 1'b1;
                    req_d.qn         = sendQN;
                    req_d.tid        = sendTID;
                    req_d.ddp_ctrl   = sendDdpCtrl;
                    req_d.rdmap_ctrl = sendRdmapCtrl;
                    req_d.rdmap_hdr  = sendRdmapHdr;
                    req_d.out_words  = new_out_words;
                    req_d.last_be    = new_last_be;
                    words_left_d     = new_out_words;
                    pops_left_d      = new_buf_words;
                    state_d          = SOP;
                end
            end
            SOP: begin
                last     = (req_q.out_words == 9'd1);
                be       = last ? req_q.last_be : 6'd21;
                pkt_data = {req_q.ddp_ctrl, req_q.rdmap_ctrl, 3'b000, req_q.qn, req_q.out_words,
                            req_q.rdmap_hdr, sendBufData[167:0]};
                if (!ddpPktFull && (!need_pop || !sendBufEmpty)) begin
                    ddpPktPush   = 1'b1;
                    sendBufPop   = need_pop;
                    words_left_d = words_left_q - 9'd1;
                    state_d      = last ? DONE : BODY;
                end
            end
            BODY: begin
                last     = (words_left_q == 9'd1);
                be       = last ? req_q.last_be : 6'd32;
                // Once the buffer is drained the final word is the residue alone.
                pkt_data = need_pop ? {sendBufData[167:0], residue_q} : {168'b0, residue_q};
                if (!ddpPktFull && (!need_pop || !sendBufEmpty)) begin
                    ddpPktPush   = 1'b1;
                    sendBufPop   = need_pop;
                    words_left_d = words_left_q - 9'd1;
                    state_d      = last ? DONE : BODY;
                end
            end
            DONE: begin
                sendDoneValid = 1'b1;
                state_d       = IDLE;
            end
        endcase

        if (sendBufPop) begin
            residue_d   = sendBufData[255:168];
            pops_left_d = pops_left_q - PC_W'(1);
        end

`ifdef DDP_ASSEMBLE_ZEROPAD_EN
        for (int i = 0; i < 32; i++) begin
            if (last && (6'(i) >= be) && (state_q == BODY || i < 21))
                pkt_data[8*i +: 8] = 8'h00;
        end
`endif

        // A packet in flight is dropped on the spot when reset arrives.
        if (reset) begin
            sendAck       = 1'b0;
            sendBufPop    = 1'b0;
            ddpPktPush    = 1'b0;
            sendDoneValid = 1'b0;
        end

        ddpPktDataIn = ddpPktPush ? {state_q == SOP, last, 3'b000, be, pkt_data} : '0;
        sendDoneCtrl = sendDoneValid ? req_q.rdmap_ctrl : 8'h00;
        sendDoneTID  = sendDoneValid ? req_q.tid : 8'h00;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            req_q        <= '0;
            words_left_q <= '0;
            pops_left_q  <= '0;
            residue_q    <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            words_left_q <= words_left_d;
            pops_left_q  <= pops_left_d;
            residue_q    <= residue_d;
        end
    end

endmodule

// File: tb/tb_ddp_assemble.sv
// Scoreboard bench for ddp_assemble: a byte-level model predicts link words, pop flags and completions;
// a monitor compares every push and done pulse. A buffer process models the show-ahead FIFO and stalls.
module tb_ddp_assemble;
    localparam int LEN_W   = 13;
    localparam int MAX_LEN = 4096;

    typedef struct packed {
        logic [266:0] word;
        logic [266:0] mask;
        logic         pop;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             sendReq;
    logic             sendAck;
    logic [3:0]       sendQN;
    logic [LEN_W-1:0] sendLen;
    logic [7:0]       sendTID;
    logic [7:0]       sendDdpCtrl;
    logic [7:0]       sendRdmapCtrl;
    logic [55:0]      sendRdmapHdr;
    logic [255:0]     sendBufData;
    logic             sendBufEmpty;
    logic             sendBufPop;
    logic [266:0]     ddpPktDataIn;
    logic             ddpPktPush;
    logic             ddpPktFull;
    logic [7:0]       sendDoneCtrl;
    logic [7:0]       sendDoneTID;
    logic             sendDoneValid;

    ddp_assemble #(.LEN_W(LEN_W), .MAX_LEN(MAX_LEN)) dut (
        .clock(clock), .reset(reset),
        .sendReq(sendReq), .sendAck(sendAck),
        .sendQN(sendQN), .sendLen(sendLen), .sendTID(sendTID),
        .sendDdpCtrl(sendDdpCtrl), .sendRdmapCtrl(sendRdmapCtrl), .sendRdmapHdr(sendRdmapHdr),
        .sendBufData(sendBufData), .sendBufEmpty(sendBufEmpty), .sendBufPop(sendBufPop),
        .ddpPktDataIn(ddpPktDataIn), .ddpPktPush(ddpPktPush), .ddpPktFull(ddpPktFull),
        .sendDoneCtrl(sendDoneCtrl), .sendDoneTID(sendDoneTID), .sendDoneValid(sendDoneValid)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int stall_pct   = 0;
    int full_burst  = 0;
    int empty_burst = 0;
    int eop_cyc     = -10;

    exp_t          exp_q[$];
    logic [15:0]   done_q[$];
    logic [255:0]  buf_q[$];
    logic [7:0]    pl[MAX_LEN];

    task automatic check(input string name, input logic [266:0] got, input logic [266:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Show-ahead buffer and transmit-FIFO model: retire popped words, draw stalls for the next cycle.
    initial begin
        bit force_empty;
        bit pop_seen;
        ddpPktFull   = 1'b0;
        sendBufEmpty = 1'b1;
        sendBufData  = '0;
        forever begin
            @(negedge clock);
            pop_seen = sendBufPop;
            @(posedge clock);
            #1;
            if (pop_seen && buf_q.size() > 0) buf_q.delete(0);
            ddpPktFull = (full_burst > 0) || (($urandom % 100) < stall_pct);
            if (full_burst > 0) full_burst--;
            force_empty = (empty_burst > 0) || (($urandom % 100) < stall_pct);
            if (empty_burst > 0) empty_burst--;
            sendBufEmpty = (buf_q.size() == 0) || force_empty;
            sendBufData  = (buf_q.size() != 0) ? buf_q[0] : rand256();
        end
    end

    // Monitor: every push and completion is matched against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (ddpPktPush) begin
                check("push_while_full", ddpPktFull, 0);
                check("push_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("pkt_word", ddpPktDataIn & e.mask, e.word & e.mask);
                    check("pop_flag", sendBufPop, e.pop);
                    if (e.word[265]) eop_cyc = cyc;
                end
            end else if (sendBufPop) begin
                check("pop_with_push", ddpPktPush, 1);
            end
            if (sendBufPop) check("pop_while_empty", sendBufEmpty, 0);
            if (sendDoneValid) begin
                check("done_expected", done_q.size() != 0, 1);
                if (done_q.size() != 0) check("done_fields", {sendDoneCtrl, sendDoneTID}, done_q.pop_front());
                check("done_latency", cyc, eop_cyc + 1);
            end
        end
    end

    task automatic send_pkt(input int len, input logic [3:0] qn, input logic [7:0] rdc, input bit rnd_data);
        int l, nbuf, nw, rem, pos, cap, cnt, bufs, prev_bufs;
        logic [7:0]   tid, ddpc;
        logic [55:0]  hdr;
        logic [255:0] w;
        exp_t         e;
        exp_t         pend[$];
        bit           got;
        l    = (len > MAX_LEN) ? MAX_LEN : len;
        tid  = 8'($urandom);
        ddpc = 8'($urandom);
        hdr  = {24'($urandom), 32'($urandom)};
        for (int i = 0; i < l; i++) pl[i] = rnd_data ? 8'($urandom) : 8'(i);
        nbuf = (l + 31) / 32;
        for (int j = 0; j < nbuf; j++) begin
            w = rand256();
            for (int k = 0; k < 32; k++) if (32*j + k < l) w[8*k +: 8] = pl[32*j + k];
            buf_q.push_back(w);
        end
        nw  = 1;
        rem = l - 21;
        while (rem > 0) begin
            nw++;
            rem -= 32;
        end
        pos       = 0;
        prev_bufs = 0;
        for (int k = 0; k < nw; k++) begin
            cap    = (k == 0) ? 21 : 32;
            cnt    = (l - pos < cap) ? l - pos : cap;
            e.word = '0;
            e.mask = '0;
            e.word[266]     = (k == 0);
            e.word[265]     = (k == nw - 1);
            e.word[264:256] = 9'(cnt);
            e.mask[266:256] = '1;
            if (k == 0) begin
                e.word[255:168] = {ddpc, rdc, 3'b000, qn, 9'(nw), hdr};
                e.mask[255:168] = '1;
            end
            for (int i = 0; i < cnt; i++) begin
                e.word[8*i +: 8] = pl[pos + i];
                e.mask[8*i +: 8] = 8'hff;
            end
            pos      += cnt;
            bufs      = (pos + 31) / 32;
            e.pop     = (bufs != prev_bufs);
            prev_bufs = bufs;
            pend.push_back(e);
        end

        sendLen       = LEN_W'(len);
        sendQN        = qn;
        sendTID       = tid;
        sendDdpCtrl   = ddpc;
        sendRdmapCtrl = rdc;
        sendRdmapHdr  = hdr;
        sendReq       = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clock);
            if (sendAck) begin
                got = 1'b1;
                break;
            end
        end
        check("ack_seen", got, 1);
        if (got) begin
            check("ack_after_done", done_q.size(), 0);
            foreach (pend[i]) exp_q.push_back(pend[i]);
            done_q.push_back({rdc, tid});
        end
        @(posedge clock);
        #2;
        sendReq = 1'b0;
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && c < 20000) begin
            @(negedge clock);
            c++;
        end
        check("drain_done", (exp_q.size() == 0) && (done_q.size() == 0), 1);
        @(posedge clock);
        #2;
        check("buf_leftover", buf_q.size(), 0);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_data"}, ddpPktDataIn, 0);
        check({name, "_ctl"}, {sendAck, sendBufPop, ddpPktPush, sendDoneValid, sendDoneCtrl, sendDoneTID}, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; sendReq = 1'b0; sendQN = '0; sendLen = '0; sendTID = '0;
        sendDdpCtrl = '0; sendRdmapCtrl = '0; sendRdmapHdr = '0;
        repeat (3) @(posedge clock);
        #2;
        @(negedge clock);
        check_quiet("reset");
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(negedge clock);
        check_quiet("idle");
        @(posedge clock);
        #2;

        send_pkt(10, 4'd3, 8'h05, 1'b0);
        wait_drain();
        send_pkt(32, 4'($urandom), 8'($urandom), 1'b0);
        wait_drain();
        send_pkt(85, 4'($urandom), 8'($urandom), 1'b0);
        wait_drain();

        send_pkt(100, 4'($urandom), 8'($urandom), 1'b0);
        @(negedge clock);
        full_burst = 3;
        repeat (4) @(negedge clock);
        empty_burst = 2;
        wait_drain();

        // Zero-length packet with the next request held high while the first is in flight.
        send_pkt(0, 4'($urandom), 8'($urandom), 1'b1);
        send_pkt(10, 4'($urandom), 8'($urandom), 1'b1);
        wait_drain();

        send_pkt(5000, 4'($urandom), 8'($urandom), 1'b1);
        wait_drain();

        // Reset in the middle of a long packet, then a clean single-word packet.
        send_pkt(200, 4'($urandom), 8'($urandom), 1'b1);
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        @(negedge clock);
        check_quiet("midrst");
        @(posedge clock);
        #2;
        exp_q.delete();
        done_q.delete();
        buf_q.delete();
        @(negedge clock);
        check_quiet("midrst_held");
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(negedge clock);
        check_quiet("post_rst");
        repeat (5) @(negedge clock);
        @(posedge clock);
        #2;
        send_pkt(21, 4'($urandom), 8'($urandom), 1'b1);
        wait_drain();

        for (int n = 0; n < 30; n++) begin
            int r;
            int len;
            stall_pct = $urandom_range(30, 0);
            r = $urandom_range(9, 0);
            if (r < 6)      len = $urandom_range(100, 0);
            else if (r < 9) len = $urandom_range(700, 101);
            else            len = $urandom_range(8191, 0);
            send_pkt(len, 4'($urandom), 8'($urandom), 1'b1);
            if ($urandom_range(3, 0) == 0) repeat ($urandom_range(4, 1)) @(posedge clock);
        end
        wait_drain();
        stall_pct = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddp_assemble.md
Name: ddp_assemble

Overview:
- Transmit-side DDP packet builder: takes a send request (queue, RDMAP/DDP header fields, payload byte length) and pulls payload words from the show-ahead send buffer.
- Emits 267-bit link words into the transmit async FIFO: 11-bit sideband plus 256-bit data, with header fields packed into the SOP word.
- Realigns payload across word boundaries with an 11-byte residue register.
- Reports completion on sendDone* to the receive-side header logic.

Parameters:
- LEN_W, 13, width of payload byte length.
- MAX_LEN, 4096, largest legal payload in bytes; larger requests are clamped to MAX_LEN.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sendReq  in  1  request valid; held until sendAck
- sendAck  out  1  one-cycle pulse, request accepted
- sendQN  in  4  destination queue number
- sendLen  in  LEN_W  payload bytes
- sendTID  in  8  transaction id
- sendDdpCtrl  in  8  DDP control byte
- sendRdmapCtrl  in  8  RDMAP control byte
- sendRdmapHdr  in  56  RDMAP header
- sendBufData  in  256  show-ahead payload word; byte k at bits [8k+7:8k]
- sendBufEmpty  in  1  send buffer empty
- sendBufPop  out  1  consume sendBufData
- ddpPktDataIn  out  267  {sop, eop, byteEnable[8:0], data[255:0]}
- ddpPktPush  out  1  write ddpPktDataIn
- ddpPktFull  in  1  transmit FIFO full
- sendDoneCtrl  out  8  RDMAP control of finished packet
- sendDoneTID  out  8  TID of finished packet
- sendDoneValid  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, SOP, BODY, DONE.
- Reset: state IDLE, residue cleared. Outputs are 0: sendAck, sendBufPop, ddpPktPush, ddpPktDataIn, sendDone*.
- Reset mid-packet: abort immediately, no eop and no sendDoneValid for the aborted packet.

IDLE:
- On sendReq, latch all request fields and pulse sendAck.
- Compute L = min(sendLen, MAX_LEN).
- Compute outWords = (L<=21) ? 1 : 1+ceil((L-21)/32).
- Compute bufWords = ceil(L/32).
- Go to SOP.
- sendReq is ignored outside IDLE.

SOP word layout:
- [266] sop=1; [265] eop=(outWords==1); [264:256] byteEnable.
- [255:248] ddpCtrl; [247:240] rdmapCtrl; [239:224] ddpHdr = {3'b0, QN[3:0], outWords[8:0]}; [223:168] rdmapHdr.
- [167:0] payload bytes 0..20.

SOP word issue:
- Requires !ddpPktFull, and also !sendBufEmpty when L>0.
- Same cycle: push the word, pop the buffer word, capture buffer bytes 21..31 into residue[87:0].
- L=0: header-only word, byteEnable=0, eop=1, no pop.

BODY word layout and issue:
- Word n = {sendBufData[167:0], residue} when a buffer word remains; otherwise {168'b0, residue} (final word served from residue, no pop).
- Pop and push happen in the same cycle; residue is reloaded from sendBufData[255:168] on each pop.
- Stall (no push, no pop, all state held) while ddpPktFull, or while a pop is required and sendBufEmpty.

byteEnable:
- Count of valid payload bytes in the word (not a mask).
- Non-last words: 21 for the SOP word, 32 for BODY words.
- Last word: L if outWords==1, else ((L-22) mod 32)+1.
- eop=1 on the last word only.

DONE:
- Entered in the cycle after the eop push.
- sendDoneValid=1 for exactly one cycle, with sendDoneCtrl=rdmapCtrl and sendDoneTID=TID; then IDLE.
- First possible sendAck for the next request is the following cycle.

Counters:
- Word counter 9 bits; buffer pop counter LEN_W-5 bits.
- No wrap: counters are reloaded per packet.
- Pops per packet equal bufWords exactly.

Throughput: one link word per cycle when unstalled.

Optional Feature:
- Macro: DDP_ASSEMBLE_ZEROPAD_EN.
- Defined: bytes beyond byteEnable in the last word are forced to 0, covering both the SOP payload area and BODY data.
- Undefined: those bytes carry whatever buffer or residue content is present; no masking logic is synthesized.

Test Plan:
- L=10, QN=3, rdmapCtrl=0x05: one word with sop=1, eop=1, byteEnable=10, ddpHdr=0x0601; exactly 1 pop; sendDoneValid 1 cycle after push, with TID echoed.
- L=32, buffer word bytes = index: 2 words; word1 bytes 0..20; word2 byteEnable=11 holding bytes 21..31 at [87:0]; 1 pop total; second push made without a pop.
- L=85: outWords=3, bufWords=3; byteEnables 21/32/32; eop on word 3; bytes 21..84 contiguous across words.
- L=100 with ddpPktFull asserted 3 cycles mid-BODY and sendBufEmpty asserted 2 cycles: no push or pop while stalled; data identical to the unstalled run.
- L=0: single header-only word with byteEnable=0, no pop; sendReq held during busy is acknowledged only after DONE.
- reset asserted mid-BODY of an L=200 packet: outputs 0 next cycle, no sendDoneValid; the next L=21 request yields a clean single sop/eop word.
